// File: rtl/snk_bg_pixel_shifter.sv
// snk_bg_pixel_shifter: two-bank 4-bitplane background tile serialiser with VDG blanking.
// Optional SNK_ATTR_HFLIP_EN: top rom_attr bit is a per-tile h-flip, stripped from pix_out.
module snk_bg_pixel_shifter #(
  parameter int ATTR_W = 4,
  parameter int PLANES = 4
) (
  input  logic                     clk,
  input  logic                     Reset_n,
  input  logic                     Cen,
  input  logic                     PLOAD_RSHIFTn,
  input  logic                     RL_Sel,
  input  logic                     AB_Sel,
  input  logic                     VDG,
  input  logic [31:0]              rom_data,
`ifdef SNK_ATTR_HFLIP_EN
  input  logic [ATTR_W:0]          rom_attr,
`else
  input  logic [ATTR_W-1:0]        rom_attr,
`endif
  input  logic                     LD_A,
  input  logic                     LD_B,
  output logic [ATTR_W+PLANES-1:0] pix_out,
  output logic                     pix_opaque,
  output logic                     underrun
);
`ifdef SNK_ATTR_HFLIP_EN
  localparam int AW = ATTR_W + 1;
`else
  localparam int AW = ATTR_W;
`endif
  logic [PLANES-1:0][7:0] bank_a, bank_b, pl, pl_nxt, sel_d;
  logic [AW-1:0]          attr_a, attr_b, sel_a;
  logic [ATTR_W-1:0]      attr_q;
  logic [PLANES-1:0]      colour;
  logic [3:0]             cnt;
  logic                   dir_q, flip;
  assign sel_d = AB_Sel ? bank_b : bank_a;
  assign sel_a = AB_Sel ? attr_b : attr_a;
`ifdef SNK_ATTR_HFLIP_EN
  assign flip = sel_a[ATTR_W];
`else
  assign flip = 1'b0;
`endif
  always_comb begin
    colour = '0;
    pl_nxt = '0;
    for (int i = 0; i < PLANES; i++) begin
      colour[i] = dir_q ? pl[i][7] : pl[i][0];
      pl_nxt[i] = dir_q ? {pl[i][6:0], 1'b0} : {1'b0, pl[i][7:1]};
    end
  end
  // bank capture ignores Cen so the ROM fetch can land on any clock
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bank_a <= '0;
      bank_b <= '0;
      attr_a <= '0;
      attr_b <= '0;
    end else begin
      if (LD_A) begin
        bank_a <= rom_data;
        attr_a <= rom_attr;
      end
      if (LD_B) begin
        bank_b <= rom_data;
        attr_b <= rom_attr;
      end
    end
  end
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pl         <= '0;
      attr_q     <= '0;
      dir_q      <= 1'b0;
      cnt        <= '0;
      pix_out    <= '0;
      pix_opaque <= 1'b0;
      underrun   <= 1'b0;
    end else if (Cen) begin
      pix_out    <= VDG ? {attr_q, colour} : '0;
      pix_opaque <= VDG & (|colour);
      if (!PLOAD_RSHIFTn) begin
        pl       <= sel_d;
        attr_q   <= sel_a[ATTR_W-1:0];
        dir_q    <= RL_Sel ^ flip;
        cnt      <= 4'd8;
        underrun <= 1'b0;
      end else begin
        pl       <= pl_nxt;
        cnt      <= (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
        underrun <= underrun | (cnt == 4'd0);
      end
    end
  end
endmodule

// File: tb/tb_snk_bg_pixel_shifter.sv
// tb_snk_bg_pixel_shifter: directed + random checks against a pixel-queue reference model.
module tb_snk_bg_pixel_shifter;
`ifdef SNK_ATTR_HFLIP_EN
  localparam int AW = 5;
`else
  localparam int AW = 4;
`endif
  logic          clk = 0, Reset_n = 0, Cen = 0, PLOAD_RSHIFTn = 1, RL_Sel = 1, AB_Sel = 0, VDG = 1, LD_A = 0, LD_B = 0;
  logic [31:0]   rom_data = '0;
  logic [AW-1:0] rom_attr = '0;
  logic [7:0]    pix_out;
  logic          pix_opaque, underrun;
  int            checks = 0, errors = 0;
  logic [31:0]   ma, mb;
  logic [AW-1:0] maa, mba;
  logic [3:0]    m_attr;
  logic [3:0]    q[$];
  logic [7:0]    m_pix;
  logic          m_opq, m_und;
  snk_bg_pixel_shifter dut (
    .clk(clk), .Reset_n(Reset_n), .Cen(Cen), .PLOAD_RSHIFTn(PLOAD_RSHIFTn), .RL_Sel(RL_Sel),
    .AB_Sel(AB_Sel), .VDG(VDG), .rom_data(rom_data), .rom_attr(rom_attr), .LD_A(LD_A), .LD_B(LD_B),
    .pix_out(pix_out), .pix_opaque(pix_opaque), .underrun(underrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic flip_of(input logic [AW-1:0] a);
`ifdef SNK_ATTR_HFLIP_EN
    return a[AW-1];
`else
    return 1'b0;
`endif
  endfunction
  task automatic model_reset();
    ma = '0; mb = '0; maa = '0; mba = '0; m_attr = '0;
    q.delete();
    m_pix = '0; m_opq = 0; m_und = 0;
  endtask
  // one clock: drive at negedge, update model at posedge, compare just after
  task automatic cyc(input logic cen, pld, rl, ab, vdg, lda, ldb, input logic [31:0] d, input logic [AW-1:0] at);
    logic [31:0] sd;
    logic [AW-1:0] sa;
    logic [3:0] head;
    logic dir;
    int b;
    @(negedge clk);
    Cen = cen; PLOAD_RSHIFTn = pld; RL_Sel = rl; AB_Sel = ab; VDG = vdg;
    LD_A = lda; LD_B = ldb; rom_data = d; rom_attr = at;
    @(posedge clk);
    if (cen) begin
      head = (q.size() > 0) ? q[0] : 4'h0;
      m_pix = vdg ? {m_attr, head} : 8'h00;
      m_opq = vdg && (head != 0);
      if (!pld) begin
        sd = ab ? mb : ma;
        sa = ab ? mba : maa;
        dir = rl ^ flip_of(sa);
        m_attr = sa[3:0];
        q.delete();
        for (int k = 0; k < 8; k++) begin
          b = dir ? 7 - k : k;
          q.push_back({sd[24+b], sd[16+b], sd[8+b], sd[b]});
        end
        m_und = 0;
      end else if (q.size() == 0) m_und = 1;
      else void'(q.pop_front());
    end
    if (lda) begin ma = d; maa = at; end
    if (ldb) begin mb = d; mba = at; end
    #1;
    chk("pix", pix_out, m_pix);
    chk("opq", pix_opaque, m_opq);
    chk("und", underrun, m_und);
  endtask
  task automatic ld(input logic to_b, input logic [31:0] d, input logic [AW-1:0] at);
    cyc(0, 1, 1, 0, 1, !to_b, to_b, d, at);
  endtask
  task automatic load(input logic ab, rl);
    cyc(1, 0, rl, ab, 1, 0, 0, 32'h0, '0);
  endtask
  task automatic sh(input logic vdg);
    cyc(1, 1, 1, 0, vdg, 0, 0, 32'h0, '0);
  endtask
  initial begin
    model_reset();
    #1;
    chk("rst_pix", pix_out, 8'h00);
    chk("rst_und", underrun, 1'b0);
    @(negedge clk) Reset_n = 1;
    ld(0, 32'h0000_0081, 4'h5);
    load(0, 1);
    for (int i = 0; i < 8; i++) begin
      sh(1);
      chk("seq81_msb", pix_out, (i == 0 || i == 7) ? 8'h51 : 8'h50);
    end
    load(0, 0);
    for (int i = 0; i < 8; i++) sh(1);
    ld(0, 32'h0000_0001, 4'h5);
    load(0, 0);
    sh(1);
    chk("seq01_lsb_first", pix_out, 8'h51);
    for (int i = 0; i < 7; i++) sh(1);
    load(0, 1);
    for (int i = 0; i < 8; i++) sh(1);
    chk("seq01_msb_last", pix_out, 8'h51);
    ld(0, 32'h8000_0000, 4'h0);
    ld(1, 32'h0080_0000, 4'h0);
    cyc(1, 0, 1, 1, 1, 0, 1, 32'hFFFF_FFFF, 4'h3);
    sh(1);
    chk("bank_b_old", pix_out, 8'h04);
    load(1, 1);
    sh(1);
    chk("bank_b_new", pix_out, 8'h3F);
    for (int i = 0; i < 7; i++) sh(1);
    chk("und_at8", underrun, 1'b0);
    sh(1);
    chk("und_at9", underrun, 1'b1);
    chk("und_colour", pix_out[3:0], 4'h0);
    load(0, 1);
    chk("und_clear", underrun, 1'b0);
    ld(0, 32'hFFFF_FFFF, 4'hA);
    load(0, 1);
    for (int i = 0; i < 8; i++) begin
      sh(!(i == 2 || i == 3));
      chk("vdg_pix", pix_out, (i == 2 || i == 3) ? 8'h00 : 8'hAF);
      chk("vdg_opq", pix_opaque, !(i == 2 || i == 3));
    end
    load(0, 1);
    sh(1);
    sh(1);
    #2 Reset_n = 0;
    #1;
    chk("arst_pix", pix_out, 8'h00);
    chk("arst_opq", pix_opaque, 1'b0);
    chk("arst_und", underrun, 1'b0);
    model_reset();
    @(negedge clk) Reset_n = 1;
`ifdef SNK_ATTR_HFLIP_EN
    ld(0, 32'h0000_0001, 5'h15);
    load(0, 1);
    sh(1);
    chk("hflip_first", pix_out, 8'h51);
`endif
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom),
          $urandom_range(0, 5) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          $urandom, AW'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
